// File: rtl/display_arbiter_if.sv
// Requester/display-driver bundle for display_arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface display_arbiter_if;
   logic [3:0]   req;
   logic [127:0] data_in;
   logic [3:0]   grant;
   logic [1:0]   owner_id;
   logic         busy;
   logic [31:0]  num_to_display;

   modport master (
      output req, data_in,
      input  grant, owner_id, busy, num_to_display
   );

   modport slave (
      input  req, data_in,
      output grant, owner_id, busy, num_to_display
   );
endinterface

// File: rtl/display_arbiter.sv
// Shares one 8-digit hex display among four requesters with a minimum dwell per owner.
// Define DISPLAY_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module display_arbiter #(
   parameter int HOLD_CYCLES = 100000
) (
   input logic              clk,
   input logic              reset,
   display_arbiter_if.slave bus
);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, OWN, EXPIRED} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_grant;
   logic [1:0]       r_owner;
   logic             r_busy;
   logic [31:0]      r_num;

   logic [3:0] w_mask;
   logic       w_found;
   logic [1:0] w_win;
   logic       w_owner_req;
   logic       w_expired;
   logic       w_take;

   assign bus.grant          = r_grant;
   assign bus.owner_id       = r_owner;
   assign bus.busy           = r_busy;
   assign bus.num_to_display = r_num;

   // The owner never competes against itself; in IDLE r_grant is zero.
   assign w_mask      = bus.req & ~r_grant;
   assign w_owner_req = bus.req[r_owner];
   // The edge on which the counter reaches its last value already counts as expired.
   assign w_expired   = (r_state == EXPIRED) || ((r_state == OWN) && (r_cnt == CNT_LAST));
   assign w_take      = w_found && ((r_state == IDLE) || !w_owner_req || w_expired);

`ifdef DISPLAY_ARB_FIXED_PRIO_EN
   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      w_found = 1'b0;
      w_win   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_mask[i]) begin
            w_found = 1'b1;
            w_win   = 2'(i);
         end
      end
   end
`else
   logic [1:0] r_last;
   logic [1:0] w_idx;

   // Scan from farthest to nearest so the nearest hit after r_last wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = 2'd0;
      w_idx   = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         w_idx = r_last + 2'(i);
         if (w_mask[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 2'd3;
      end else if (w_take) begin
         r_last <= w_win;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_grant <= 4'b0000;
         r_owner <= 2'd0;
         r_busy  <= 1'b0;
         r_num   <= 32'd0;
      end else if (w_take) begin
         r_state <= OWN;
         r_cnt   <= '0;
         r_grant <= 4'b0001 << w_win;
         r_owner <= w_win;
         r_busy  <= 1'b1;
         r_num   <= bus.data_in[32*w_win +: 32];
      end else if (r_state != IDLE) begin
         if (!w_owner_req) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
         end else begin
            r_num <= bus.data_in[32*r_owner +: 32];
            if (r_state == OWN) begin
               if (r_cnt == CNT_LAST) r_state <= EXPIRED;
               else                   r_cnt   <= r_cnt + 1'b1;
            end
         end
      end
   end
endmodule
